// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 frame decoder writing the PWM control registers; SPI_READBACK_EN adds cipo readback
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ncs,
  input  logic        copi,
  output logic        cipo,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty,
  output logic        frame_ok,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_s, ncs_s, copi_s;
  logic sclk_d, ncs_d, sclk_rise, ncs_rise, ncs_fall, bit_in;
  logic [15:0] sr;
  logic [4:0] cnt;
  logic [6:0] addr;
  logic do_ok, do_err, do_wr;
  // Sync chains reset low so a frame already in flight at reset release shows no ncs fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      ncs_s  <= '0;
      copi_s <= '0;
      sclk_d <= 1'b0;
      ncs_d  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      ncs_s  <= {ncs_s[SYNC_STAGES-2:0], ncs};
      copi_s <= {copi_s[SYNC_STAGES-2:0], copi};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      ncs_d  <= ncs_s[SYNC_STAGES-1];
    end
  end
  assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_d;
  assign ncs_rise  = ncs_s[SYNC_STAGES-1] & ~ncs_d;
  assign ncs_fall  = ~ncs_s[SYNC_STAGES-1] & ncs_d;
  assign bit_in    = copi_s[SYNC_STAGES-1];
  assign addr      = sr[14:8];
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state;
    do_ok   = 1'b0;
    do_err  = 1'b0;
    do_wr   = 1'b0;
    state_n = state == IDLE  ? (ncs_fall ? SHIFT : IDLE) :
              state == SHIFT ? (ncs_rise ? COMMIT : SHIFT) : IDLE;
    do_ok   = state == COMMIT && cnt == 5'd16 && (!sr[15] || addr <= MAX_ADDR);
    do_err  = state == COMMIT && !do_ok;
    do_wr   = do_ok && sr[15];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      en_out    <= '0;
      en_pwm    <= '0;
      duty      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= do_ok;
      frame_err <= do_err;
      if (state == IDLE && ncs_fall) begin
        sr  <= '0;
        cnt <= '0;
      end else if (state == SHIFT && sclk_rise) begin
        sr  <= {sr[14:0], bit_in};
        cnt <= cnt == 5'd17 ? cnt : cnt + 5'd1;
      end
      if (do_wr && addr == 7'd0) en_out[7:0]  <= sr[7:0];
      if (do_wr && addr == 7'd1) en_out[15:8] <= sr[7:0];
      if (do_wr && addr == 7'd2) en_pwm[7:0]  <= sr[7:0];
      if (do_wr && addr == 7'd3) en_pwm[15:8] <= sr[7:0];
      if (do_wr && addr == 7'd4) duty         <= sr[7:0];
    end
  end
`ifdef SPI_READBACK_EN
  logic sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_val, out_sh;
  assign sclk_fall = ~sclk_s[SYNC_STAGES-1] & sclk_d;
  // At the 8th rise the R/W bit and the first six address bits are in sr; the last address bit is arriving.
  assign rd_addr = {sr[5:0], bit_in};
  assign rd_val  = rd_addr > MAX_ADDR ? 8'h00 :
                   rd_addr == 7'd0 ? en_out[7:0] :
                   rd_addr == 7'd1 ? en_out[15:8] :
                   rd_addr == 7'd2 ? en_pwm[7:0] :
                   rd_addr == 7'd3 ? en_pwm[15:8] :
                   rd_addr == 7'd4 ? duty : 8'h00;
  // The fall right after the load is skipped so bit 7 is still presented at the 9th rise.
  always_ff @(posedge clk) begin
    if (rst || state_n != SHIFT) out_sh <= '0;
    else if (state == SHIFT && sclk_rise && cnt == 5'd7 && !sr[6]) out_sh <= rd_val;
    else if (sclk_fall && cnt >= 5'd9 && cnt <= 5'd15) out_sh <= {out_sh[6:0], 1'b0};
  end
  assign cipo = out_sh[7];
`else
  assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed SPI frames against spi_reg_ctrl with hand-computed expectations
module tb_spi_reg_ctrl;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, ncs = 1'b1, copi = 1'b0;
  logic cipo, frame_ok, frame_err;
  logic [15:0] en_out, en_pwm;
  logic [7:0] duty, rd;
  int n_vec = 0, n_err = 0, lat, oks, errs;
  logic [7:0] rd_exp;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
    .en_out(en_out), .en_pwm(en_pwm), .duty(duty),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic b, output logic c);
    @(negedge clk) copi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    c = cipo;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic end_frame(output int l, output int o, output int e);
    repeat (2) @(negedge clk);
    ncs = 1'b1;
    l = 0; o = 0; e = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk) #1;
      if ((frame_ok || frame_err) && l == 0) l = k;
      o += int'(frame_ok);
      e += int'(frame_err);
    end
  endtask

  task automatic frame(input logic [16:0] bits, input int n, output logic [7:0] r,
                       output int l, output int o, output int e);
    logic c;
    r = '0;
    @(negedge clk) ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bit_out(bits[n-1-i], c);
      if (i >= 8 && i <= 15) r = {r[6:0], c};
    end
    end_frame(l, o, e);
  endtask

  initial begin
    logic c;
`ifdef SPI_READBACK_EN
    rd_exp = 8'h5A;
`else
    rd_exp = 8'h00;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_en_out", en_out, 0);
    chk("rst_en_pwm", en_pwm, 0);
    chk("rst_duty", duty, 0);
    chk("rst_cipo", cipo, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    repeat (4) @(negedge clk);

    frame(17'h080F0, 16, rd, lat, oks, errs);
    chk("w0_lat", lat, 4);
    chk("w0_ok", oks, 1);
    chk("w0_err", errs, 0);
    chk("w0_en_out", en_out, 16'h00F0);
    frame(17'h08480, 16, rd, lat, oks, errs);
    chk("w4_lat", lat, 4);
    chk("w4_ok", oks, 1);
    chk("w4_duty", duty, 8'h80);
    chk("w4_en_out", en_out, 16'h00F0);

    frame(17'h085AA, 16, rd, lat, oks, errs);
    chk("badaddr_err", errs, 1);
    chk("badaddr_ok", oks, 0);
    chk("badaddr_lat", lat, 4);
    chk("badaddr_regs", {en_out, en_pwm}, 32'h00F0_0000);
    chk("badaddr_duty", duty, 8'h80);

    frame(17'h0417F, 15, rd, lat, oks, errs);
    chk("short_err", errs, 1);
    chk("short_ok", oks, 0);
    chk("short_en_pwm", en_pwm, 0);
    frame(17'h105FF, 17, rd, lat, oks, errs);
    chk("long_err", errs, 1);
    chk("long_ok", oks, 0);
    chk("long_en_pwm", en_pwm, 0);

    @(negedge clk) ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) bit_out(i < 8 ? (8'h83 >> (7 - i)) & 1'b1 : 1'b1, c);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_en_out", en_out, 0);
    chk("midrst_duty", duty, 0);
    for (int i = 0; i < 6; i++) bit_out(1'b1, c);
    end_frame(lat, oks, errs);
    chk("midrst_ok", oks, 0);
    chk("midrst_err", errs, 0);
    chk("midrst_en_pwm", en_pwm, 0);
    frame(17'h0830F, 16, rd, lat, oks, errs);
    chk("w3_ok", oks, 1);
    chk("w3_en_pwm", en_pwm, 16'h0F00);

    frame(17'h0815A, 16, rd, lat, oks, errs);
    chk("w1_ok", oks, 1);
    chk("w1_en_out", en_out, 16'h5A00);
    frame(17'h00100, 16, rd, lat, oks, errs);
    chk("rd_ok", oks, 1);
    chk("rd_err", errs, 0);
    chk("rd_lat", lat, 4);
    chk("rd_data", rd, rd_exp);
    chk("rd_cipo_idle", cipo, 0);
    chk("rd_regs", {en_out, en_pwm}, 32'h5A00_0F00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
